// File: rtl/imem_if.sv
// Fetch and program-load bus between the PC/IF stage and the loadable instruction memory.
// master = pipeline/loader side, slave = memory side.
interface imem_if;
    logic [31:0] pc;
    logic        fetch_en;
    logic        stall;
    logic        flush;
    logic [31:0] Instruction_Code;
    logic        instr_valid;
    logic        fault;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_done;

    modport master (
        output pc, fetch_en, stall, flush,
        input  Instruction_Code, instr_valid, fault,
        output ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready, ld_done
    );

    modport slave (
        input  pc, fetch_en, stall, flush,
        output Instruction_Code, instr_valid, fault,
        input  ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready, ld_done
    );
endinterface

// File: rtl/imem_loadable.sv
// Byte-addressed, runtime-loadable instruction memory with a registered, stallable, flushable fetch port.
// Optional address checking is enabled by defining IMEM_FAULT_CHECK_EN.
module imem_loadable #(
    parameter int          DEPTH_BYTES = 256,
    parameter int          AW          = 8,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    imem_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [7:0]  mem_r [DEPTH_BYTES];

    logic [31:0] instr_r;
    logic        valid_r;
    logic        fault_r;
    logic [31:0] instr_nxt_s;
    logic        valid_nxt_s;
    logic        fault_nxt_s;

    logic        ld_hs_s;
    logic        ld_bad_s;
    logic        ld_we_s;
    logic [AW-1:0] ld_idx_s;

    logic [AW-1:0] idx0_s;
    logic [AW-1:0] idx1_s;
    logic [AW-1:0] idx2_s;
    logic [AW-1:0] idx3_s;
    logic [31:0]   rd_word_s;
    logic          fetch_bad_s;

    // Bits above the index width only matter for range checks.
    logic          unused_hi_s;
    assign unused_hi_s = ^{bus.pc[31:AW], bus.ld_addr[31:AW]};

    // Loader handshake is only possible while loading.
    assign ld_hs_s  = bus.ld_valid && (state_r == ST_LOAD);
    assign ld_idx_s = bus.ld_addr[AW-1:0];
    assign ld_we_s  = ld_hs_s && !ld_bad_s;

    // Byte index arithmetic wraps at AW bits, so the last word can straddle the top of the array.
    assign idx0_s = bus.pc[AW-1:0];
    assign idx1_s = idx0_s + AW'(1);
    assign idx2_s = idx0_s + AW'(2);
    assign idx3_s = idx0_s + AW'(3);
    assign rd_word_s = {mem_r[idx0_s], mem_r[idx1_s], mem_r[idx2_s], mem_r[idx3_s]};

`ifdef IMEM_FAULT_CHECK_EN
    assign fetch_bad_s = (bus.pc[1:0] != 2'b00) || (bus.pc >= 32'(DEPTH_BYTES - 3));
    assign ld_bad_s    = (bus.ld_addr >= 32'(DEPTH_BYTES));
`else
    assign fetch_bad_s = 1'b0;
    assign ld_bad_s    = 1'b0;
`endif

    // Byte array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_we_s) begin
            mem_r[ld_idx_s] <= bus.ld_data;
        end
    end

    // Next-state and next fetch-register values.
    always_comb begin
        state_nxt_s = state_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        fault_nxt_s = fault_r;
        case (state_r)
            ST_LOAD: begin
                instr_nxt_s = NOP_WORD;
                valid_nxt_s = 1'b0;
                fault_nxt_s = ld_hs_s && ld_bad_s;
                if (ld_hs_s && bus.ld_last) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
                if (bus.flush) begin
                    instr_nxt_s = NOP_WORD;
                    valid_nxt_s = 1'b0;
                    fault_nxt_s = 1'b0;
                end else if (bus.stall) begin
                    instr_nxt_s = instr_r;
                    valid_nxt_s = valid_r;
                    fault_nxt_s = fault_r;
                end else if (bus.fetch_en) begin
                    if (fetch_bad_s) begin
                        instr_nxt_s = NOP_WORD;
                        valid_nxt_s = 1'b0;
                        fault_nxt_s = 1'b1;
                    end else begin
                        instr_nxt_s = rd_word_s;
                        valid_nxt_s = 1'b1;
                        fault_nxt_s = 1'b0;
                    end
                end else begin
                    instr_nxt_s = instr_r;
                    valid_nxt_s = 1'b0;
                    fault_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                instr_nxt_s = NOP_WORD;
                valid_nxt_s = 1'b0;
                fault_nxt_s = 1'b0;
            end
        endcase
    end

    // State and fetch output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_LOAD;
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            instr_r <= instr_nxt_s;
            valid_r <= valid_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    assign bus.Instruction_Code = instr_r;
    assign bus.instr_valid      = valid_r;
    assign bus.fault            = fault_r;
    assign bus.ld_ready         = (state_r == ST_LOAD);
    assign bus.ld_done          = (state_r == ST_RUN);

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: load, fetch, stall, flush, wrap/fault and async reset.
module tb_imem_loadable;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    imem_if bus ();

    imem_loadable #(
        .DEPTH_BYTES(256),
        .AW(8),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.pc       = a;
        bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.pc = 32'd0; bus.fetch_en = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = 32'd0; bus.ld_data = 8'd0; bus.ld_last = 1'b0;
        tick(); tick();
        chk("rst_instr", bus.Instruction_Code, 32'h0000_0000);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("rst_done",  {31'd0, bus.ld_done}, 32'd0);
        reset = 1'b1;
        tick();

        // Auxiliary bytes for the wrap and dropped-load checks.
        load_byte(32'd44, 8'h11, 1'b0);
        load_byte(32'd45, 8'h22, 1'b0);
        load_byte(32'd46, 8'h33, 1'b0);
        load_byte(32'd47, 8'h44, 1'b0);
        load_byte(32'd254, 8'ha1, 1'b0);
        load_byte(32'd255, 8'hb2, 1'b0);
        load_byte(32'd300, 8'h5a, 1'b0);
`ifdef IMEM_FAULT_CHECK_EN
        chk("ld_oob_fault", {31'd0, bus.fault}, 32'd1);
`else
        chk("ld_oob_fault", {31'd0, bus.fault}, 32'd0);
`endif
        // Junk image, then an asynchronous reset after three bytes.
        load_byte(32'd0, 8'hff, 1'b0);
        chk("ld_fault_clr", {31'd0, bus.fault}, 32'd0);
        load_byte(32'd1, 8'hee, 1'b0);
        load_byte(32'd2, 8'hdd, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midload_rst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("midload_rst_done",  {31'd0, bus.ld_done}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        load_byte(32'd0, 8'h8c, 1'b0);
        load_byte(32'd1, 8'h22, 1'b0);
        load_byte(32'd2, 8'h00, 1'b0);
        load_byte(32'd3, 8'h04, 1'b0);
        load_byte(32'd4, 8'h00, 1'b0);
        load_byte(32'd5, 8'h45, 1'b0);
        fetch(32'd0);
        chk("midload_fetch_instr", bus.Instruction_Code, 32'h0000_0000);
        chk("midload_fetch_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("midload_ready", {31'd0, bus.ld_ready}, 32'd1);
        load_byte(32'd6, 8'h20, 1'b0);
        // fetch_en during the final handshake must be ignored.
        bus.pc = 32'd0;
        bus.fetch_en = 1'b1;
        load_byte(32'd7, 8'h24, 1'b1);
        bus.fetch_en = 1'b0;
        chk("last_hs_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("last_hs_instr", bus.Instruction_Code, 32'h0000_0000);
        chk("done_after_last", {31'd0, bus.ld_done}, 32'd1);
        chk("ready_after_last", {31'd0, bus.ld_ready}, 32'd0);

        fetch(32'd0);
        chk("fetch0_instr", bus.Instruction_Code, 32'h8c22_0004);
        chk("fetch0_valid", {31'd0, bus.instr_valid}, 32'd1);
        bus.stall = 1'b1;
        bus.fetch_en = 1'b1;
        bus.pc = 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", bus.Instruction_Code, 32'h8c22_0004);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        tick();
        bus.fetch_en = 1'b0;
        chk("post_stall_instr", bus.Instruction_Code, 32'h0045_2024);
        chk("post_stall_valid", {31'd0, bus.instr_valid}, 32'd1);
        tick();
        chk("idle_instr_hold", bus.Instruction_Code, 32'h0045_2024);
        chk("idle_valid", {31'd0, bus.instr_valid}, 32'd0);

        fetch(32'd0);
        chk("refetch0", bus.Instruction_Code, 32'h8c22_0004);
        bus.flush = 1'b1; bus.stall = 1'b1; bus.fetch_en = 1'b1; bus.pc = 32'd4;
        tick();
        bus.flush = 1'b0; bus.stall = 1'b0; bus.fetch_en = 1'b0;
        chk("flush_instr", bus.Instruction_Code, 32'h0000_0000);
        chk("flush_valid", {31'd0, bus.instr_valid}, 32'd0);

        fetch(32'd44);
`ifdef IMEM_FAULT_CHECK_EN
        chk("fetch44_dropped", bus.Instruction_Code, 32'h1122_3344);
`else
        chk("fetch44_wrapped", bus.Instruction_Code, 32'h5a22_3344);
`endif
        chk("fetch44_fault", {31'd0, bus.fault}, 32'd0);

        fetch(32'd254);
`ifdef IMEM_FAULT_CHECK_EN
        chk("pc254_fault", {31'd0, bus.fault}, 32'd1);
        chk("pc254_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("pc254_instr", bus.Instruction_Code, 32'h0000_0000);
`else
        chk("pc254_instr", bus.Instruction_Code, 32'ha1b2_8c22);
        chk("pc254_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("pc254_fault", {31'd0, bus.fault}, 32'd0);
`endif
        fetch(32'd2);
`ifdef IMEM_FAULT_CHECK_EN
        chk("pc2_fault", {31'd0, bus.fault}, 32'd1);
        chk("pc2_valid", {31'd0, bus.instr_valid}, 32'd0);
`else
        chk("pc2_instr", bus.Instruction_Code, 32'h0004_0045);
        chk("pc2_valid", {31'd0, bus.instr_valid}, 32'd1);
`endif

        // Loads in RUN are ignored.
        load_byte(32'd0, 8'h77, 1'b0);
        fetch(32'd0);
        chk("run_load_ignored", bus.Instruction_Code, 32'h8c22_0004);
        chk("run_fault_clr", {31'd0, bus.fault}, 32'd0);

        #2 reset = 1'b0;
        #1;
        chk("run_rst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("run_rst_done",  {31'd0, bus.ld_done}, 32'd0);
        chk("run_rst_instr", bus.Instruction_Code, 32'h0000_0000);
        chk("run_rst_valid", {31'd0, bus.instr_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
